// File: rtl/gate_vector_checker.sv
// Stimulus driver and response checker for the 2-bit NOT/AND/OR/NAND/NOR/XOR/XNOR gate set.
// Drives one vector at a time, waits a settle window, then scores the seven gate outputs.
`timescale 1ns/1ps
module gate_vector_checker #(
  parameter int WIDTH  = 2,
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic             vec_in,
  output logic [WIDTH-1:0] drv_a,
  output logic [WIDTH-1:0] drv_b,
  output logic             drv_in,
  input  logic             y_not,
  input  logic [WIDTH-1:0] y_and,
  input  logic [WIDTH-1:0] y_or,
  input  logic [WIDTH-1:0] y_nand,
  input  logic [WIDTH-1:0] y_nor,
  input  logic [WIDTH-1:0] y_xor,
  input  logic [WIDTH-1:0] y_xnor,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [6:0]       err_mask,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SC_W-1:0]  settle_cnt;
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] n_vec;
  logic [6:0]       mism;
  logic             accept;
  logic             last_vec;

  // A start coinciding with a handshake wins; that vector is never taken.
  assign accept   = (state == S_RUN) && vec_valid && !start;
  assign last_vec = (idx + CNT_W'(1)) == n_vec;

  assign vec_ready = (state == S_RUN);
  assign busy      = (state == S_RUN) || (state == S_SETTLE) || (state == S_CHECK);
  assign done      = (state == S_DONE);

  // Case inequality so that X/Z on a gate output is scored as a mismatch in simulation.
  assign mism[0] = (y_not  !== ~drv_in);
  assign mism[1] = (y_and  !== (drv_a & drv_b));
  assign mism[2] = (y_or   !== (drv_a | drv_b));
  assign mism[3] = (y_nand !== ~(drv_a & drv_b));
  assign mism[4] = (y_nor  !== ~(drv_a | drv_b));
  assign mism[5] = (y_xor  !== (drv_a ^ drv_b));
  assign mism[6] = (y_xnor !== ~(drv_a ^ drv_b));

  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_RUN:    if (accept) state_nxt = S_SETTLE;
      S_SETTLE: if (settle_cnt == '0) state_nxt = S_CHECK;
      S_CHECK:  state_nxt = last_vec ? S_DONE : S_RUN;
      default:  ;
    endcase
    if (start) state_nxt = (num_vectors == '0) ? S_DONE : S_RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drv_a          <= '0;
      drv_b          <= '0;
      drv_in         <= 1'b0;
      settle_cnt     <= '0;
      idx            <= '0;
      n_vec          <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err_mask       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else if (start) begin
      idx            <= '0;
      n_vec          <= num_vectors;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      err_mask       <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (accept) begin
            drv_a      <= vec_a;
            drv_b      <= vec_b;
            drv_in     <= vec_in;
            settle_cnt <= SC_W'(SETTLE - 1);
          end
        end
        S_SETTLE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - SC_W'(1);
        end
        S_CHECK: begin
          if (mism == '0) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            fail_cnt <= fail_cnt + CNT_W'(1);
            err_mask <= err_mask | mism;
            if (!first_fail_vld) begin
              first_fail_idx <= idx;
              first_fail_vld <= 1'b1;
            end
          end
          idx <= idx + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Self-checking bench for gate_vector_checker: fault-injecting gate model plus a
// session-level scoreboard computed from gate truth tables.
`timescale 1ns/1ps
module tb_gate_vector_checker;

  localparam int WIDTH  = 2;
  localparam int CNT_W  = 8;
  localparam int SETTLE = 2;

  typedef struct packed {
    logic [1:0] a;
    logic [1:0] b;
    logic       in;
    logic [6:0] flip;   // invert bit 0 of the selected gates
    logic       xs1;    // y_xor[0] stuck at 1
    logic       n11;    // y_nand forced to 2'b11
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic             vec_valid = 1'b0;
  logic             vec_ready;
  logic [WIDTH-1:0] vec_a = '0, vec_b = '0;
  logic             vec_in = 1'b0;
  logic [WIDTH-1:0] drv_a, drv_b;
  logic             drv_in;
  logic             y_not;
  logic [WIDTH-1:0] y_and, y_or, y_nand, y_nor, y_xor, y_xnor;
  logic             busy, done;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
  logic [6:0]       err_mask;
  logic             first_fail_vld;

  vec_t flt = '0;
  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  gate_vector_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_in(vec_in),
    .drv_a(drv_a), .drv_b(drv_b), .drv_in(drv_in),
    .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_nand(y_nand),
    .y_nor(y_nor), .y_xor(y_xor), .y_xnor(y_xnor),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .err_mask(err_mask), .first_fail_idx(first_fail_idx), .first_fail_vld(first_fail_vld)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Gate instances under test, with injectable faults.
  assign y_not  = ~drv_in ^ flt.flip[0];
  assign y_and  = (drv_a & drv_b) ^ WIDTH'(flt.flip[1]);
  assign y_or   = (drv_a | drv_b) ^ WIDTH'(flt.flip[2]);
  assign y_nand = flt.n11 ? 2'b11 : (~(drv_a & drv_b) ^ WIDTH'(flt.flip[3]));
  assign y_nor  = ~(drv_a | drv_b) ^ WIDTH'(flt.flip[4]);
  assign y_xor  = ((drv_a ^ drv_b) ^ WIDTH'(flt.flip[5])) | WIDTH'(flt.xs1);
  assign y_xnor = ~(drv_a ^ drv_b) ^ WIDTH'(flt.flip[6]);

  // Reference: which gates disagree with their truth table for this vector and fault.
  function automatic logic [6:0] expected_mism(input vec_t v);
    int a, b, t[7], o[7];
    logic [6:0] m;
    a = int'(v.a); b = int'(v.b);
    t[0] = v.in ? 0 : 1;
    t[1] = a & b;          t[2] = a | b;
    t[3] = 3 - (a & b);    t[4] = 3 - (a | b);
    t[5] = a ^ b;          t[6] = 3 - (a ^ b);
    for (int g = 0; g < 7; g++) o[g] = v.flip[g] ? (t[g] ^ 1) : t[g];
    if (v.xs1) o[5] = o[5] | 1;
    if (v.n11) o[3] = 3;
    for (int g = 0; g < 7; g++) m[g] = (o[g] != t[g]);
    return m;
  endfunction

  task automatic start_session(input int n);
    @(negedge clk);
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_vector(input vec_t v);
    int waited = 0;
    vec_valid = 1'b1;
    vec_a = v.a; vec_b = v.b; vec_in = v.in;
    while (!vec_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (!vec_ready) begin
      errors++;
      $display("FAIL send_timeout: vec_ready=%b after %0d cycles, required 1", vec_ready, waited);
    end else begin
      @(posedge clk);
      #1;
      flt = v;
      vec_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({drv_a, drv_b, drv_in} !== {v.a, v.b, v.in}) begin
        errors++;
        $display("FAIL drv_hold: drv=%b/%b/%b required %b/%b/%b", drv_a, drv_b, drv_in, v.a, v.b, v.in);
      end
    end
  endtask

  task automatic wait_done(input string name);
    int waited = 0;
    while (!done && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b, required 1", name, done);
    end
  endtask

  // Runs vq as one session and scores the result against the reference.
  task automatic run_session(input string name);
    int e_pass = 0, e_fail = 0, e_first = -1;
    logic [6:0] e_mask = '0, m;
    flt = '0;
    start_session(vq.size());
    foreach (vq[i]) send_vector(vq[i]);
    wait_done(name);
    foreach (vq[i]) begin
      m = expected_mism(vq[i]);
      if (m == '0) e_pass++;
      else begin
        e_fail++;
        e_mask |= m;
        if (e_first < 0) e_first = i;
      end
    end
    checks += 5;
    if (pass_cnt !== CNT_W'(e_pass)) begin
      errors++; $display("FAIL %s_pass_cnt: got %0d, required %0d", name, pass_cnt, e_pass);
    end
    if (fail_cnt !== CNT_W'(e_fail)) begin
      errors++; $display("FAIL %s_fail_cnt: got %0d, required %0d", name, fail_cnt, e_fail);
    end
    if (err_mask !== e_mask) begin
      errors++; $display("FAIL %s_err_mask: got %b, required %b", name, err_mask, e_mask);
    end
    if (first_fail_vld !== (e_first >= 0)) begin
      errors++; $display("FAIL %s_first_vld: got %b, required %b", name, first_fail_vld, e_first >= 0);
    end
    if (first_fail_idx !== CNT_W'(e_first < 0 ? 0 : e_first)) begin
      errors++; $display("FAIL %s_first_idx: got %0d, required %0d", name, first_fail_idx, e_first);
    end
    if ({busy, vec_ready} !== 2'b00) begin
      errors++; $display("FAIL %s_idle_flags: busy/ready=%b, required 00", name, {busy, vec_ready});
    end
  endtask

  task automatic load_ramp(input logic xs1);
    vec_t v;
    vq.delete();
    for (int i = 0; i < 4; i++) begin
      v = '0;
      v.a = 2'(i); v.b = 2'(i); v.in = i[0]; v.xs1 = xs1;
      vq.push_back(v);
    end
  endtask

  task automatic test_reset();
    vec_t v = '0;
    @(negedge clk);
    checks++;
    if ({vec_ready, busy, done, pass_cnt, fail_cnt, err_mask, first_fail_idx, first_fail_vld,
         drv_a, drv_b, drv_in} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all zero under rst");
    end
    rst = 1'b0;
    start_session(3);
    v.a = 2'b11; v.b = 2'b01; v.in = 1'b1;
    send_vector(v);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({vec_ready, busy, done, pass_cnt, fail_cnt, err_mask, first_fail_vld,
         drv_a, drv_b, drv_in} !== '0) begin
      errors++; $display("FAIL reset_mid_settle: busy=%b drv_a=%b drv_in=%b, required all 0", busy, drv_a, drv_in);
    end
    @(negedge clk);
    checks++;
    if ({vec_ready, busy, drv_a} !== '0) begin
      errors++; $display("FAIL reset_next_cycle: ready=%b busy=%b drv_a=%b, required 0", vec_ready, busy, drv_a);
    end
    rst = 1'b0;
    vq.delete();
    vq.push_back(v);
    v.a = 2'b10; v.flip = 7'b0000010;
    vq.push_back(v);
    run_session("after_reset");
  endtask

  task automatic test_all_pass();
    load_ramp(1'b0);
    run_session("all_pass");
    checks++;
    if ({pass_cnt, fail_cnt, err_mask, first_fail_vld} !== {8'd4, 8'd0, 7'd0, 1'b0}) begin
      errors++; $display("FAIL all_pass_const: pass=%0d fail=%0d mask=%b, required 4/0/0", pass_cnt, fail_cnt, err_mask);
    end
  endtask

  task automatic test_xor_stuck();
    load_ramp(1'b1);
    run_session("xor_stuck");
    checks++;
    if ({fail_cnt, err_mask, first_fail_idx} !== {8'd4, 7'b0100000, 8'd0}) begin
      errors++; $display("FAIL xor_stuck_const: fail=%0d mask=%b first=%0d, required 4/0100000/0", fail_cnt, err_mask, first_fail_idx);
    end
  endtask

  task automatic test_nand_idx2();
    load_ramp(1'b0);
    vq[2].n11 = 1'b1;
    run_session("nand_idx2");
    checks++;
    if ({pass_cnt, fail_cnt, err_mask, first_fail_idx} !== {8'd3, 8'd1, 7'b0001000, 8'd2}) begin
      errors++; $display("FAIL nand_idx2_const: pass=%0d fail=%0d mask=%b first=%0d, required 3/1/0001000/2", pass_cnt, fail_cnt, err_mask, first_fail_idx);
    end
  endtask

  task automatic test_zero_vectors();
    logic saw_ready = 1'b0;
    start_session(0);
    checks++;
    if ({done, busy, pass_cnt, fail_cnt, err_mask, first_fail_vld} !== {1'b1, 1'b0, 24'd0}) begin
      errors++; $display("FAIL zero_vec_done: done=%b busy=%b pass=%0d fail=%0d, required 1/0/0/0", done, busy, pass_cnt, fail_cnt);
    end
    vec_valid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (vec_ready) saw_ready = 1'b1;
    end
    vec_valid = 1'b0;
    checks++;
    if (saw_ready !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL zero_vec_ready: saw_ready=%b done=%b, required 0/1", saw_ready, done);
    end
  endtask

  task automatic test_back_to_back();
    int c0, c1, waited;
    flt = '0;
    start_session(6);
    vec_valid = 1'b1; vec_a = 2'b01; vec_b = 2'b10; vec_in = 1'b0;
    waited = 0;
    while (!vec_ready && waited < 20) begin @(negedge clk); waited++; end
    c0 = cyc;
    repeat (3) @(negedge clk);
    checks++;
    if ({vec_ready, busy, pass_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      errors++; $display("FAIL b2b_check_cycle: ready=%b pass=%0d, required 0/0", vec_ready, pass_cnt);
    end
    @(negedge clk);
    checks++;
    if ({vec_ready, pass_cnt} !== {1'b1, 8'd1}) begin
      errors++; $display("FAIL b2b_update: ready=%b pass=%0d, required 1/1", vec_ready, pass_cnt);
    end
    @(negedge clk);
    waited = 0;
    while (!vec_ready && waited < 20) begin @(negedge clk); waited++; end
    c1 = cyc;
    checks++;
    if (c1 - c0 !== 2 * (SETTLE + 2)) begin
      errors++; $display("FAIL b2b_period: two periods took %0d cycles, required %0d", c1 - c0, 2 * (SETTLE + 2));
    end
    start = 1'b1; num_vectors = 8'd2;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, pass_cnt, fail_cnt} !== {1'b1, 16'd0}) begin
      errors++; $display("FAIL b2b_restart_clear: busy=%b pass=%0d fail=%0d, required 1/0/0", busy, pass_cnt, fail_cnt);
    end
    wait_done("b2b");
    vec_valid = 1'b0;
    checks++;
    if ({pass_cnt, fail_cnt} !== {8'd2, 8'd0}) begin
      errors++; $display("FAIL b2b_restart_count: pass=%0d fail=%0d, required 2/0", pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_random();
    vec_t v;
    int n;
    for (int s = 0; s < 4; s++) begin
      vq.delete();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        v = '0;
        v.a = 2'($urandom); v.b = 2'($urandom); v.in = 1'($urandom);
        if ($urandom_range(0, 2) == 0) v.flip = 7'($urandom);
        v.xs1 = ($urandom_range(0, 7) == 0);
        v.n11 = ($urandom_range(0, 7) == 0);
        vq.push_back(v);
      end
      run_session($sformatf("random%0d", s));
    end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_xor_stuck();
    test_nand_idx2();
    test_zero_vectors();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
